// File: rtl/iro_capture.sv
// iro_capture: synchronizes the ring-oscillator taps, counts tap-0 rising
// edges over a gate window, snapshots all taps at window end and returns
// the result over a valid/ready handshake.
module iro_capture #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic [15:0]       phases,
  output logic              ro_enable,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CNT_W-1:0]  edge_count,
  output logic [15:0]       snapshot,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       sync1;
  logic [15:0]       sync2;
  logic              prev0;
  logic              rise;
  logic [GATE_W-1:0] remaining;
  logic              last_cycle;

  // Two-flop synchronizer on every tap plus the tap-0 edge register; free-running.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev0 <= 1'b0;
    end else begin
      sync1 <= phases;
      sync2 <= sync1;
      prev0 <= sync2[0];
    end
  end

  assign rise       = sync2[0] & ~prev0;
  assign last_cycle = (remaining == GATE_W'(1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt    = state;
    ro_enable    = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ARM;
      end
      ARM: begin
        ro_enable = 1'b1;
        state_nxt = (remaining == '0) ? DONE : COUNT;
      end
      COUNT: begin
        ro_enable = 1'b1;
        if (last_cycle) state_nxt = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gate countdown, saturating edge counter, overflow flag and snapshot capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining  <= '0;
      edge_count <= '0;
      snapshot   <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) remaining <= gate_cycles;
        end
        ARM: begin
          edge_count <= '0;
          overflow   <= 1'b0;
          if (remaining == '0) snapshot <= sync2;
        end
        COUNT: begin
          if (rise) begin
            if (edge_count == CNT_MAX) overflow   <= 1'b1;
            else                       edge_count <= edge_count + 1'b1;
          end
          remaining <= remaining - GATE_W'(1);
          if (last_cycle) snapshot <= sync2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iro_capture.sv
// Self-checking bench for iro_capture: a 16-bit and a 4-bit counter instance
// share stimulus; expectations come from a history of sampled taps.
module tb_iro_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        result_ready;
  logic [15:0] gate_cycles;
  logic [15:0] phases;

  logic        ro_enable, busy, result_valid, overflow;
  logic [15:0] edge_count, snapshot;
  logic        ro_enable4, busy4, result_valid4, overflow4;
  logic [3:0]  edge_count4;
  logic [15:0] snapshot4;

  int n_total = 0;
  int n_bad   = 0;

  // Tap values as seen by the synchronizer at each clock edge (zeroed by reset).
  int          ecnt = 0;
  logic [15:0] eff [0:4095];

  int          ph_mode = 0;      // 0: constant, >0: square period on tap 0, <0: random
  logic [15:0] ph_base = 16'hA5A4;
  int          gcnt    = 0;

  always #5 clk = ~clk;

  iro_capture #(.GATE_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .gate_cycles(gate_cycles),
    .phases(phases), .ro_enable(ro_enable), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .edge_count(edge_count), .snapshot(snapshot), .overflow(overflow)
  );

  iro_capture #(.GATE_W(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .gate_cycles(gate_cycles),
    .phases(phases), .ro_enable(ro_enable4), .busy(busy4),
    .result_valid(result_valid4), .result_ready(result_ready),
    .edge_count(edge_count4), .snapshot(snapshot4), .overflow(overflow4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record what the synchronizer's first stage takes at each edge.
  always @(posedge clk) begin
    ecnt = ecnt + 1;
    eff[ecnt] = rst ? 16'h0000 : phases;
    if (rst) begin
      if (ecnt >= 1) eff[ecnt-1] = 16'h0000;
      if (ecnt >= 2) eff[ecnt-2] = 16'h0000;
    end
  end

  // Tap stimulus generator.
  initial begin
    phases = 16'hA5A4;
    forever begin
      @(posedge clk);
      #1;
      gcnt++;
      if (ph_mode > 0)      phases = {ph_base[15:1], (gcnt % ph_mode) < (ph_mode / 2)};
      else if (ph_mode < 0) phases = 16'($urandom);
      else                  phases = ph_base;
    end
  end

  // Accepted at edge k with window g: edges seen in sync2 at edges k+2..k+1+g
  // (tap history is two edges behind sync2, three behind the edge register).
  task automatic model(input int k, input int g, input int cap,
                       output int c, output bit o, output logic [15:0] s);
    int n = 0;
    for (int e = k + 2; e <= k + 1 + g; e++)
      if (eff[e-2][0] === 1'b1 && eff[e-3][0] === 1'b0) n++;
    c = (n > cap) ? cap : n;
    o = (n > cap);
    s = (g == 0) ? eff[k-1] : eff[k+g-1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_meas(input string nm, input int g, input int rdly, input bit inject,
                          input bit chain, input int g_next);
    int k, lat, roc, bz, unst, c16, c4;
    bit o16, o4;
    logic [15:0] s16, s4;
    if (start !== 1'b1) begin
      gate_cycles = 16'(g);
      start = 1'b1;
    end
    tick();
    k = ecnt;
    start = 1'b0;
    gate_cycles = 16'($urandom);
    lat = 0; roc = 0; bz = 0;
    while (result_valid !== 1'b1 && lat < g + 20) begin
      if (ro_enable === 1'b1) roc++;
      if (busy !== 1'b1) bz++;
      start = inject && g > 0 && lat == g / 2 + 1;
      result_ready = inject ? 1'($urandom) : 1'b0;
      tick();
      lat++;
    end
    start = 1'b0;
    result_ready = 1'b0;
    check_val({nm, ".latency"}, lat, g + 1);
    check_val({nm, ".ro_cycles"}, roc, g + 1);
    check_val({nm, ".busy_low"}, bz, 0);
    check_val({nm, ".ro_in_done"}, ro_enable, 0);
    check_val({nm, ".valid4"}, result_valid4, 1);
    model(k, g, 65535, c16, o16, s16);
    model(k, g, 15, c4, o4, s4);
    check_val({nm, ".count"}, edge_count, c16);
    check_val({nm, ".ovf"}, overflow, o16);
    check_val({nm, ".snap"}, snapshot, s16);
    check_val({nm, ".count4"}, edge_count4, c4);
    check_val({nm, ".ovf4"}, overflow4, o4);
    check_val({nm, ".snap4"}, snapshot4, s4);
    unst = 0;
    for (int i = 0; i < rdly; i++) begin
      start = inject && i == 0;
      tick();
      if (result_valid !== 1'b1 || busy !== 1'b1 || ro_enable !== 1'b0 ||
          edge_count !== 16'(c16) || overflow !== o16 || snapshot !== s16 ||
          edge_count4 !== 4'(c4) || overflow4 !== o4) unst++;
    end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_val({nm, ".hold"}, unst, 0);
    check_val({nm, ".idle_busy"}, busy, 0);
    check_val({nm, ".idle_valid"}, result_valid, 0);
    check_val({nm, ".idle_count"}, edge_count, c16);
    check_val({nm, ".idle_valid4"}, result_valid4, 0);
    if (chain) begin
      gate_cycles = 16'(g_next);
      start = 1'b1;
    end
  endtask

  task automatic reset_mid(input int g, input int at);
    int nv = 0;
    gate_cycles = 16'(g);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (at) tick();
    check_val("rstmid.was_counting", ro_enable, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rstmid.busy", busy, 0);
    check_val("rstmid.ro", ro_enable, 0);
    check_val("rstmid.count", edge_count, 0);
    check_val("rstmid.snap", snapshot, 0);
    check_val("rstmid.ovf", overflow, 0);
    check_val("rstmid.valid", result_valid, 0);
    check_val("rstmid.count4", edge_count4, 0);
    repeat (g + 10) begin
      tick();
      if (result_valid !== 1'b0 || busy !== 1'b0 || result_valid4 !== 1'b0) nv++;
    end
    check_val("rstmid.no_result", nv, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    result_ready = 1'b0;
    gate_cycles = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("reset.busy", busy, 0);
    check_val("reset.ro", ro_enable, 0);
    check_val("reset.valid", result_valid, 0);
    check_val("reset.count", edge_count, 0);
    check_val("reset.snap", snapshot, 0);
    check_val("reset.ovf", overflow, 0);
    check_val("reset.count4", edge_count4, 0);
    repeat (4) tick();

    ph_mode = 8;
    repeat (3) tick();
    run_meas("basic", 80, 2, 1'b0, 1'b0, 0);
    check_val("basic.ten", edge_count, 10);

    ph_mode = 2;
    repeat (3) tick();
    run_meas("sat", 40, 0, 1'b0, 1'b0, 0);
    check_val("sat.count4_max", edge_count4, 15);
    check_val("sat.ovf4_set", overflow4, 1);

    ph_mode = 0;
    repeat (3) tick();
    run_meas("zero", 0, 1, 1'b0, 1'b0, 0);
    check_val("zero.count", edge_count, 0);

    ph_mode = 8;
    repeat (2) tick();
    run_meas("bp", 30, 5, 1'b1, 1'b0, 0);
    repeat (3) tick();
    check_val("bp.idle_hold", busy, 0);

    ph_mode = 2;
    repeat (2) tick();
    reset_mid(50, 10);

    ph_mode = 4;
    repeat (4) tick();
    run_meas("b2b_a", 30, 1, 1'b0, 1'b1, 8);
    run_meas("b2b_b", 8, 0, 1'b0, 1'b0, 0);
    check_val("b2b.second", edge_count, 2);

    ph_mode = -1;
    repeat (3) tick();
    for (int r = 0; r < 8; r++) begin
      run_meas("rnd", int'($urandom_range(40, 0)), int'($urandom_range(4, 0)),
               1'($urandom), 1'b0, 0);
      repeat ($urandom_range(3, 0)) tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
